// File: rtl/ahb_bridge_req_arbiter.sv
// Round-robin arbiter sharing the bridge AHB slave port among N_MST hold-until-done requesters.
// Latency: request in cycle 0 -> address phase cycle 1 -> data phase and o_done cycle 2 (no waits).
// Backpressure: i_hreadyout low stalls ADDR/DATA one cycle each; i_sleep_req blocks new grants.
module ahb_bridge_req_arbiter #(
  parameter int N_MST      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          i_clk_src,
  input  logic                          i_rstn_src,
  input  logic [N_MST-1:0]              i_req,
  input  logic [N_MST-1:0]              i_write,
  input  logic [3*N_MST-1:0]            i_size,
  input  logic [ADDR_WIDTH*N_MST-1:0]   i_addr,
  input  logic [DATA_WIDTH*N_MST-1:0]   i_wdata,
  output logic [N_MST-1:0]              o_done,
  output logic                          o_err,
  output logic [DATA_WIDTH-1:0]         o_rdata,
  output logic [N_MST-1:0]              o_grant,
  input  logic                          i_sleep_req,
  output logic                          o_sleep_ack,
  output logic                          o_hselx,
  output logic                          o_htrans,
  output logic                          o_hwrite,
  output logic [2:0]                    o_hsize,
  output logic [ADDR_WIDTH-1:0]         o_haddr,
  output logic [DATA_WIDTH-1:0]         o_hwdata,
  output logic                          o_hready,
  input  logic                          i_hreadyout,
  input  logic                          i_hresp,
  input  logic [DATA_WIDTH-1:0]         i_hrdata
);

  localparam int IW = (N_MST > 1) ? $clog2(N_MST) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                 state, state_nxt;
  logic [IW-1:0]          owner, owner_nxt;
  logic [IW-1:0]          rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]          pick;
  logic                   pick_vld;
  logic [IW:0]            pick_sum;
  logic [2*N_MST-1:0]     req_rot;
  logic [N_MST-1:0]       owner_oh;

  // Rotate the request vector so bit 0 is the requester at rr_ptr; doubling avoids a wrap special case.
  assign req_rot  = {i_req, i_req} >> rr_ptr;
  assign owner_oh = N_MST'(1) << owner;
  assign o_hready = i_hreadyout;

  // Lowest set bit of the rotated vector, mapped back to an absolute requester index.
  always_comb begin
    pick_vld = 1'b0;
    pick_sum = '0;
    for (int k = N_MST - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_vld = 1'b1;
        pick_sum = {1'b0, rr_ptr} + (IW+1)'(k);
      end
    end
    if (pick_sum >= (IW+1)'(N_MST)) begin
      pick_sum = pick_sum - (IW+1)'(N_MST);
    end
    pick = pick_sum[IW-1:0];
  end

  // State, owner and round-robin pointer registers.
  always_ff @(posedge i_clk_src or negedge i_rstn_src) begin
    if (!i_rstn_src) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Sleep acknowledge: only asserted from IDLE so no transfer is ever in flight when it is high.
  always_ff @(posedge i_clk_src or negedge i_rstn_src) begin
    if (!i_rstn_src) begin
      o_sleep_ack <= 1'b0;
    end else if (!i_sleep_req) begin
      o_sleep_ack <= 1'b0;
    end else if (state == IDLE) begin
      o_sleep_ack <= 1'b1;
    end
  end

  // Next-state logic and AHB/requester outputs; everything idles at zero outside its phase.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    o_hselx    = 1'b0;
    o_htrans   = 1'b0;
    o_hwrite   = 1'b0;
    o_hsize    = 3'd0;
    o_haddr    = '0;
    o_hwdata   = '0;
    o_done     = '0;
    o_rdata    = '0;
    o_err      = 1'b0;
    o_grant    = '0;
    case (state)
      IDLE: begin
        if (!i_sleep_req && pick_vld) begin
          owner_nxt = pick;
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        o_hselx  = 1'b1;
        o_htrans = 1'b1;
        o_hwrite = i_write[owner];
        o_hsize  = i_size[3*int'(owner) +: 3];
        o_haddr  = i_addr[ADDR_WIDTH*int'(owner) +: ADDR_WIDTH];
        o_grant  = owner_oh;
        if (i_hreadyout) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        o_hwdata = i_wdata[DATA_WIDTH*int'(owner) +: DATA_WIDTH];
        o_grant  = owner_oh;
        if (i_hreadyout) begin
          o_done     = owner_oh;
          o_rdata    = i_hrdata;
          o_err      = i_hresp;
          rr_ptr_nxt = (owner == IW'(N_MST - 1)) ? '0 : owner + IW'(1);
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/ahb_bridge_req_arbiter.md
# ahb_bridge_req_arbiter

Round-robin scheduler that shares the AHB slave port of the AHB-to-APB bridge between `N_MST` on-chip requesters in the source clock domain. Each requester uses a simple hold-until-done request interface. The arbiter converts one granted request at a time into an AHB address phase plus a data phase on the bridge's slave port, and returns the response to the owner. It also gates new grants during a sleep handshake, so the bridge source side is only put to sleep with no transfer in flight.

## Interface
- `N_MST`, default 2: number of requesters, 2..8.
- `DATA_WIDTH`, default 32: data bus width.
- `ADDR_WIDTH`, default 32: address bus width.

Ports (name, direction, width, meaning):
- `i_clk_src` in 1: single clock.
- `i_rstn_src` in 1: reset, asynchronous, active-low.
- `i_req` in `N_MST`: per-requester request, held until `o_done[i]`.
- `i_write` in `N_MST`: per-requester direction, 1 = write.
- `i_size` in `3*N_MST`: per-requester HSIZE; slice i is `[3i+2:3i]`.
- `i_addr` in `ADDR_WIDTH*N_MST`: per-requester address.
- `i_wdata` in `DATA_WIDTH*N_MST`: per-requester write data.
- `o_done` out `N_MST`: one-cycle completion pulse to the owner.
- `o_err` out 1: response error, valid with any `o_done` bit.
- `o_rdata` out `DATA_WIDTH`: read data, valid with any `o_done` bit.
- `o_grant` out `N_MST`: one-hot owner during ADDR/DATA, else 0.
- `i_sleep_req` in 1: request to quiesce.
- `o_sleep_ack` out 1: quiesced, no transfer in flight.
- `o_hselx`, `o_htrans`, `o_hwrite` out 1 each: to bridge `i_hselx`, `i_htrans`, `i_hwrite`.
- `o_hsize` out 3: to bridge `i_hsize`.
- `o_haddr` out `ADDR_WIDTH`: to bridge `i_haddr`.
- `o_hwdata` out `DATA_WIDTH`: to bridge `i_hwdata`.
- `o_hready` out 1: to bridge `i_hready`; equals `i_hreadyout`.
- `i_hreadyout`, `i_hresp` in 1 each: from the bridge.
- `i_hrdata` in `DATA_WIDTH`: from the bridge.

## Operation
- FSM states are IDLE, ADDR and DATA. Registers are `state`, `owner` (log2 `N_MST`) and `rr_ptr` (log2 `N_MST`).
- IDLE:
  - If `i_sleep_req`=1, no grant is made; stay in IDLE.
  - Otherwise, if any `i_req` bit is set, search upward from `rr_ptr`, modulo `N_MST`. The first requester with `i_req` set becomes `owner`. Go to ADDR.
- ADDR:
  - Drive `o_hselx`=1, `o_htrans`=1.
  - Drive `o_hwrite`, `o_hsize`, `o_haddr` from the owner's slices.
  - If `i_hreadyout`=1, go to DATA; otherwise hold.
- DATA:
  - Drive `o_hselx`=0, `o_htrans`=0, `o_hwdata` = owner's `i_wdata`.
  - When `i_hreadyout`=1:
    - Set `o_done[owner]`=1, `o_rdata`=`i_hrdata`, `o_err`=`i_hresp` (combinational, same cycle).
    - Set `rr_ptr` = (owner+1) mod `N_MST`.
    - Go to IDLE.
- `o_hwdata` is 0 outside DATA. `o_haddr`, `o_hsize` and `o_hwrite` are 0 outside ADDR. `o_rdata`=0 and `o_err`=0 when no `o_done` bit is set.
- `o_grant` is one-hot on `owner` in ADDR and DATA, else 0.
- Sleep behaviour:
  - `o_sleep_ack` is registered. It is set on the edge where state is IDLE and `i_sleep_req`=1.
  - `o_sleep_ack` clears on the edge after `i_sleep_req` falls.
  - A sleep request arriving in ADDR or DATA lets that transfer complete, then the block holds in IDLE.
  - `i_sleep_req` and `i_req` both active in IDLE: sleep wins, no grant.
- `i_req` dropped by the owner mid-transfer is ignored; the transfer completes. Requester inputs must stay stable until `o_done`.
- A requester whose `i_req` is still high after `o_done` is a new request, arbitrated in the next IDLE.

## Timing
- Reset value of every output is 0. The exception is `o_hready`, which always equals `i_hreadyout`.
- Reset state: IDLE, `owner`=0, `rr_ptr`=0, `o_sleep_ack`=0.
- Asserting reset mid-transfer returns to IDLE immediately with all outputs 0 and no `o_done` pulse. The bridge is reset alongside.
- Latency with no wait states: `i_req` high in cycle 0 gives ADDR in cycle 1, DATA in cycle 2, and `o_done` in cycle 2.
- Peak throughput is one transfer per 3 cycles.
- Each cycle of `i_hreadyout`=0 in ADDR or DATA adds one cycle.
- Fairness: a requester waits at most `N_MST`-1 transfers after its `i_req` rises.
- Pointer wrap: owner `N_MST`-1 sets `rr_ptr`=0.

## Test plan
- Single write: requester 0, addr 0x0000_1000, wdata 0xDEAD_BEEF, size 2, `i_hreadyout`=1 throughout -> ADDR at cycle 1 with `o_haddr`=0x1000, `o_hwrite`=1; `o_hwdata`=0xDEADBEEF and `o_done`=01 at cycle 2.
- Contention: requesters 0 and 1 raise `i_req` together and hold it for two transfers each -> grant order 0,1,0,1; `o_done` pulses at cycles 2, 5, 8, 11.
- Wait states: read by requester 1, `i_hreadyout` low for 2 cycles in ADDR and 3 in DATA, `i_hrdata`=0x1234_5678 -> `o_done`=10 at cycle 7 with `o_rdata`=0x12345678, `o_err`=0.
- Error: `i_hresp`=1 in the completing DATA cycle -> `o_err`=1 with `o_done`; `rr_ptr` advances normally.
- Sleep: `i_sleep_req` rises during DATA of requester 0 while requester 1 is pending -> transfer completes, `o_sleep_ack`=1 on the next edge, no ADDR while asleep. After `i_sleep_req` falls, `o_sleep_ack`=0 next edge and requester 1 is granted.
- Reset mid-DATA: assert `i_rstn_src`=0 -> all outputs 0 asynchronously, no `o_done`. After release, a new request is granted to requester 0 first (`rr_ptr`=0).
